// File: rtl/prog_loader.sv
// Serial program-memory loader: parses framed UART bytes into 14-bit words for the PIC program store.
// Optional inter-byte timeout is built only when LOADER_TIMEOUT_EN is defined.
module prog_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        pm_we,
    output logic [10:0] pm_addr,
    output logic [13:0] pm_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        StIdle,
        StAddrH,
        StAddrL,
        StCntH,
        StCntL,
        StDatH,
        StDatL,
        StChk
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  chk_q, chk_d;
    logic [10:0] addr_q, addr_d;
    logic [11:0] cnt_q, cnt_d;
    logic [5:0]  dat_h_q, dat_h_d;
    logic        pm_we_q, pm_we_d;
    logic [10:0] pm_addr_q, pm_addr_d;
    logic [13:0] pm_wdata_q, pm_wdata_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [7:0]  chk_sum;
    logic [11:0] word_cnt;
    logic        fmt_err;

`ifdef LOADER_TIMEOUT_EN
    logic [23:0] tmo_q, tmo_d;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign chk_sum  = chk_q + rx_data;
    assign word_cnt = {cnt_q[11:8], rx_data};

    always_comb begin
        state_d    = state_q;
        chk_d      = chk_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        dat_h_d    = dat_h_q;
        pm_we_d    = 1'b0;
        pm_addr_d  = pm_addr_q;
        pm_wdata_d = pm_wdata_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        err_d      = err_q;
        fmt_err    = 1'b0;

        if (rx_valid) begin
            // Every byte after SYNC, including CHK, feeds the running sum.
            if (state_q != StIdle) begin
                chk_d = chk_sum;
            end
            case (state_q)
                StIdle: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = StAddrH;
                        chk_d   = 8'h00;
                        err_d   = 1'b0;
                        hold_d  = 1'b1;
                    end
                end
                StAddrH: begin
                    if (|rx_data[7:3]) begin
                        fmt_err = 1'b1;
                    end else begin
                        addr_d[10:8] = rx_data[2:0];
                        state_d      = StAddrL;
                    end
                end
                StAddrL: begin
                    addr_d[7:0] = rx_data;
                    state_d     = StCntH;
                end
                StCntH: begin
                    if (|rx_data[7:4]) begin
                        fmt_err = 1'b1;
                    end else begin
                        cnt_d   = {rx_data[3:0], 8'h00};
                        state_d = StCntL;
                    end
                end
                StCntL: begin
                    if (word_cnt > 12'd2048) begin
                        fmt_err = 1'b1;
                    end else begin
                        cnt_d   = word_cnt;
                        state_d = (word_cnt == 12'd0) ? StChk : StDatH;
                    end
                end
                StDatH: begin
                    if (|rx_data[7:6]) begin
                        fmt_err = 1'b1;
                    end else begin
                        dat_h_d = rx_data[5:0];
                        state_d = StDatL;
                    end
                end
                StDatL: begin
                    pm_we_d    = 1'b1;
                    pm_addr_d  = addr_q;
                    pm_wdata_d = {dat_h_q, rx_data};
                    addr_d     = addr_q + 11'd1;
                    cnt_d      = cnt_q - 12'd1;
                    state_d    = (cnt_q == 12'd1) ? StChk : StDatH;
                end
                StChk: begin
                    if (chk_sum == 8'h00) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase

            // Reserved bits set: abandon the frame, CPU stays held.
            if (fmt_err) begin
                state_d = StIdle;
                err_d   = 1'b1;
            end
        end

`ifdef LOADER_TIMEOUT_EN
        if ((state_q == StIdle) || rx_valid) begin
            tmo_d = 24'd0;
        end else begin
            tmo_d = tmo_q + 24'd1;
        end
        if ((state_q != StIdle) && !rx_valid && ((tmo_q + 24'd1) == TIMEOUT_CYCLES)) begin
            state_d = StIdle;
            err_d   = 1'b1;
            tmo_d   = 24'd0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            chk_q      <= 8'h00;
            addr_q     <= 11'h000;
            cnt_q      <= 12'h000;
            dat_h_q    <= 6'h00;
            pm_we_q    <= 1'b0;
            pm_addr_q  <= 11'h000;
            pm_wdata_q <= 14'h0000;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            chk_q      <= chk_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            dat_h_q    <= dat_h_d;
            pm_we_q    <= pm_we_d;
            pm_addr_q  <= pm_addr_d;
            pm_wdata_q <= pm_wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 24'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign pm_we     = pm_we_q;
    assign pm_addr   = pm_addr_q;
    assign pm_wdata  = pm_wdata_q;
    assign cpu_hold  = hold_q;
    assign busy      = (state_q != StIdle);
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: frames, checksum, wrap, format errors, reset, timeout.
module tb_prog_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        pm_we;
    logic [10:0] pm_addr;
    logic [13:0] pm_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int total = 0;
    int bad   = 0;
    int wr_count = 0;

    prog_loader #(
        .SYNC_BYTE      (8'h55),
        .TIMEOUT_CYCLES (24'd100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pm_we     (pm_we),
        .pm_addr   (pm_addr),
        .pm_wdata  (pm_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pm_we === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte per call; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int wr_base;

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pm_we", pm_we, 0);
        check("rst_pm_addr", pm_addr, 0);
        check("rst_pm_wdata", pm_wdata, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        rst_n = 1'b1;
        idle(2);

        // Good frame: two words at 000/001
        send(8'h13); // ignored in IDLE
        check("idle_ignore_busy", busy, 0);
        send(8'h55);
        check("f1_hold", cpu_hold, 1);
        check("f1_busy", busy, 1);
        send(8'h00); send(8'h00); send(8'h00); send(8'h02); send(8'h30);
        check("f1_no_we_dath", pm_we, 0);
        send(8'h09);
        check("f1_w0_we", pm_we, 1);
        check("f1_w0_addr", pm_addr, 11'h000);
        check("f1_w0_data", pm_wdata, 14'h3009);
        send(8'h00);
        check("f1_we_drop", pm_we, 0);
        check("f1_addr_hold", pm_addr, 11'h000);
        check("f1_data_hold", pm_wdata, 14'h3009);
        send(8'hA4);
        check("f1_w1_we", pm_we, 1);
        check("f1_w1_addr", pm_addr, 11'h001);
        check("f1_w1_data", pm_wdata, 14'h00A4);
        check("f1_hold_mid", cpu_hold, 1);
        send(8'h21);
        check("f1_done", load_done, 1);
        check("f1_hold_rel", cpu_hold, 0);
        check("f1_busy_end", busy, 0);
        check("f1_err", load_err, 0);
        idle(1);
        check("f1_done_pulse", load_done, 0);
        check("f1_wr_count", wr_count, 2);

        // Bad checksum: writes still happen, error sticks, CPU held
        send(8'h55); send(8'h00); send(8'h00); send(8'h00); send(8'h02);
        send(8'h30); send(8'h09); send(8'h00); send(8'hA4);
        send(8'h22);
        check("f2_done", load_done, 0);
        check("f2_err", load_err, 1);
        check("f2_hold", cpu_hold, 1);
        check("f2_busy", busy, 0);
        idle(2);
        check("f2_err_sticky", load_err, 1);
        check("f2_wr_count", wr_count, 4);

        // Good frame after error clears err on SYNC and releases hold
        send(8'h55);
        check("f3_err_clr", load_err, 0);
        send(8'h00); send(8'h00); send(8'h00); send(8'h02);
        send(8'h30); send(8'h09); send(8'h00); send(8'hA4);
        send(8'h21);
        check("f3_done", load_done, 1);
        check("f3_hold", cpu_hold, 0);
        idle(1);

        // Address wrap 7FF -> 000
        send(8'h55); send(8'h07); send(8'hFF); send(8'h00); send(8'h02);
        send(8'h00); send(8'h01);
        check("wrap_w0_addr", pm_addr, 11'h7FF);
        check("wrap_w0_data", pm_wdata, 14'h0001);
        send(8'h00); send(8'h02);
        check("wrap_w1_we", pm_we, 1);
        check("wrap_w1_addr", pm_addr, 11'h000);
        check("wrap_w1_data", pm_wdata, 14'h0002);
        send(8'hF5);
        check("wrap_done", load_done, 1);
        idle(1);

        // Zero-count frame: no writes
        wr_base = wr_count;
        send(8'h55); send(8'h00); send(8'h10); send(8'h00); send(8'h00);
        send(8'hF0);
        check("zero_done", load_done, 1);
        check("zero_err", load_err, 0);
        idle(1);
        check("zero_no_write", wr_count - wr_base, 0);

        // Format error in DAT_H
        wr_base = wr_count;
        send(8'h55); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
        send(8'hC0);
        check("fmt_err", load_err, 1);
        check("fmt_busy", busy, 0);
        check("fmt_hold", cpu_hold, 1);
        check("fmt_we", pm_we, 0);
        send(8'h3F);
        check("fmt_idle_busy", busy, 0);
        check("fmt_idle_err", load_err, 1);
        idle(1);
        check("fmt_no_write", wr_count - wr_base, 0);

        // Reserved bits in ADDR_H
        send(8'h55); send(8'h08);
        check("addrh_err", load_err, 1);
        check("addrh_busy", busy, 0);

        // SYNC value inside a frame is data
        send(8'h55); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
        send(8'h00); send(8'h55);
        check("syncdata_we", pm_we, 1);
        check("syncdata_data", pm_wdata, 14'h0055);
        send(8'hAA);
        check("syncdata_done", load_done, 1);
        idle(1);

        // Count above 2048 rejected; exactly 2048 accepted
        send(8'h55); send(8'h00); send(8'h00); send(8'h08); send(8'h01);
        check("cnt_over_err", load_err, 1);
        check("cnt_over_busy", busy, 0);
        send(8'h55); send(8'h00); send(8'h00); send(8'h08); send(8'h00);
        check("cnt_max_busy", busy, 1);
        check("cnt_max_err", load_err, 0);

        // Async reset mid-frame after DAT_H
        wr_base = wr_count;
        send(8'h05);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hold", cpu_hold, 0);
        check("arst_busy", busy, 0);
        check("arst_we", pm_we, 0);
        check("arst_addr", pm_addr, 0);
        check("arst_data", pm_wdata, 0);
        check("arst_err", load_err, 0);
        check("arst_done", load_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_no_write", wr_count - wr_base, 0);

        // Clean frame after reset: one word at 123
        send(8'h55); send(8'h01); send(8'h23); send(8'h00); send(8'h01);
        send(8'h3F); send(8'hFF);
        check("post_addr", pm_addr, 11'h123);
        check("post_data", pm_wdata, 14'h3FFF);
        send(8'h9D);
        check("post_done", load_done, 1);
        check("post_hold", cpu_hold, 0);
        idle(1);

        // Inter-byte gap inside a frame
        send(8'h55); send(8'h00);
        idle(105);
`ifdef LOADER_TIMEOUT_EN
        check("tmo_err", load_err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_hold", cpu_hold, 1);
`else
        check("notmo_busy", busy, 1);
        check("notmo_err", load_err, 0);
        send(8'h00); send(8'h00); send(8'h00);
        send(8'h00);
        check("notmo_done", load_done, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
